// File: rtl/vector_pkg.sv
// Shared definitions for the vector-display frame interface.
//  - Coordinate, address and vector-word widths.
//  - Bit positions of the fields inside a vector word.
//  - Writer FSM state type.
//  - pack_vector(), used by both the writer and the decoder side.
package vector_pkg;

  localparam int DAC_WIDTH    = 8;
  localparam int ADDRESSWIDTH = 10;
  localparam int DATAWIDTH    = 18;

  // Vector word layout: [17:10]=y, [9:2]=x, [1]=EOF, [0]=draw
  localparam int VW_Y_LSB = 10;
  localparam int VW_X_LSB = 2;
  localparam int VW_EOF   = 1;
  localparam int VW_DRAW  = 0;

  typedef enum logic [1:0] {
    FILL,
    DISCARD,
    WAIT_SWAP
  } writer_state_t;

  function automatic logic [DATAWIDTH-1:0] pack_vector(
    input logic [DAC_WIDTH-1:0] x,
    input logic [DAC_WIDTH-1:0] y,
    input logic                 eof,
    input logic                 draw
  );
    logic [DATAWIDTH-1:0] w;
    w = '0;
    w[VW_Y_LSB +: DAC_WIDTH] = y;
    w[VW_X_LSB +: DAC_WIDTH] = x;
    w[VW_EOF]                = eof;
    w[VW_DRAW]               = draw;
    return w;
  endfunction

endpackage

// File: rtl/vector_frame_writer.sv
// vector_frame_writer
//  Producer side of the double-buffered vector RAM. Accepts plotted points
//  over a valid/ready stream, packs each into one vector word and writes it
//  into the bank the display is not reading. Closing a frame arms a bank
//  swap, which executes on the next rising edge of frame_drawn.
// Ports
//  clk, rst                      clock, async active-high reset
//  pt_valid/pt_ready             point handshake (pt_ready depends on state only)
//  pt_x, pt_y, pt_draw, pt_last  point coordinates, beam on, frame close
//  frame_drawn                   display frame-done level; rising edge = scan done
//  wr_en, wr_addr, wr_data       RAM write port, {write bank, word pointer}
//  rd_bank                       bank the display scans
//  swap_pulse                    one cycle, on the cycle rd_bank toggles
//  overflow                      sticky, a frame exceeded the bank depth
module vector_frame_writer
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH    = DAC_WIDTH,
  parameter int ADDRESSWIDTH = vector_pkg::ADDRESSWIDTH,
  parameter int DATAWIDTH    = vector_pkg::DATAWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  input  logic [OUT_WIDTH-1:0]    pt_x,
  input  logic [OUT_WIDTH-1:0]    pt_y,
  input  logic                    pt_draw,
  input  logic                    pt_last,
  input  logic                    frame_drawn,
  output logic                    wr_en,
  output logic [ADDRESSWIDTH-1:0] wr_addr,
  output logic [DATAWIDTH-1:0]    wr_data,
  output logic                    rd_bank,
  output logic                    swap_pulse,
  output logic                    overflow
);

  writer_state_t           state;
  logic [ADDRESSWIDTH-2:0] ptr;
  logic                    fd_q;
  logic                    fd_rise;
  logic                    accept;
  logic                    ptr_full;

  assign pt_ready = (state == FILL) || (state == DISCARD);
  assign accept   = pt_valid && pt_ready;
  assign fd_rise  = frame_drawn && !fd_q;
  assign ptr_full = (ptr == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      ptr        <= '0;
      rd_bank    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      swap_pulse <= 1'b0;
      overflow   <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      swap_pulse <= 1'b0;
      // Tracked every cycle so an edge seen outside WAIT_SWAP is consumed
      // and cannot trigger a swap later while the level stays high.
      fd_q       <= frame_drawn;
      case (state)
        FILL: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= {~rd_bank, ptr};
            // Last slot of the bank always carries EOF so the display
            // never runs past the end of a truncated frame.
            wr_data <= pack_vector(pt_x, pt_y, pt_last || ptr_full, pt_draw);
            ptr     <= ptr + 1'b1;
            if (pt_last) begin
              state <= WAIT_SWAP;
            end else if (ptr_full) begin
              overflow <= 1'b1;
              state    <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (accept && pt_last) begin
            state <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          if (fd_rise) begin
            rd_bank    <= ~rd_bank;
            swap_pulse <= 1'b1;
            ptr        <= '0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_frame_writer.sv
module tb_vector_frame_writer;

  localparam int AW    = 5;
  localparam int DW    = 18;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pt_valid = 1'b0;
  logic          pt_ready;
  logic [7:0]    pt_x = '0;
  logic [7:0]    pt_y = '0;
  logic          pt_draw = 1'b0;
  logic          pt_last = 1'b0;
  logic          frame_drawn = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_bank;
  logic          swap_pulse;
  logic          overflow;

  vector_frame_writer #(
    .OUT_WIDTH   (8),
    .ADDRESSWIDTH(AW),
    .DATAWIDTH   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .pt_x       (pt_x),
    .pt_y       (pt_y),
    .pt_draw    (pt_draw),
    .pt_last    (pt_last),
    .frame_drawn(frame_drawn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_bank    (rd_bank),
    .swap_pulse (swap_pulse),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];
  int            total = 0;
  int            bad = 0;
  int            sw_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent packing: {y, x, eof, draw}
  function automatic logic [DW-1:0] exp_word(input logic [7:0] x, input logic [7:0] y,
                                             input logic eof, input logic d);
    return {y, x, eof, d};
  endfunction

  // Monitor: pops the scoreboard on every write, also mirrors the RAM.
  always @(negedge clk) begin
    if (swap_pulse) sw_cnt++;
    if (wr_en) begin
      ram[wr_addr] = wr_data;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic d, input logic last,
                      input logic exp_wr, input logic [AW-1:0] ea, input logic eeof,
                      input logic fd_same);
    int n;
    exp_t e;
    @(negedge clk);
    pt_valid = 1'b1;
    pt_x = x; pt_y = y; pt_draw = d; pt_last = last;
    if (fd_same) frame_drawn = 1'b1;
    n = 0;
    while (!pt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pt_ready) begin
      chk("ready_timeout", 32'(pt_ready), 32'd1);
      pt_valid = 1'b0;
      pt_last = 1'b0;
      return;
    end
    if (exp_wr) begin
      e.a = ea;
      e.d = exp_word(x, y, eeof, d);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    pt_valid = 1'b0;
    pt_last = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  // Produce a clean 0->1 on frame_drawn and expect an immediate one-cycle swap.
  task automatic edge_swap(input logic exp_bank);
    @(negedge clk); frame_drawn = 1'b0;
    @(negedge clk); frame_drawn = 1'b1;
    @(negedge clk);
    chk("swap_pulse_hi", 32'(swap_pulse), 32'd1);
    chk("rd_bank_swap", 32'(rd_bank), 32'(exp_bank));
    @(negedge clk);
    chk("swap_pulse_lo", 32'(swap_pulse), 32'd0);
  endtask

  initial begin
    int snap;
    // Reset state
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("rst_swap", 32'(swap_pulse), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ready", 32'(pt_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // 1: three-beat frame into bank 1
    send(8'd10, 8'd20, 1'b0, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b0);
    send(8'd30, 8'd40, 1'b1, 1'b0, 1'b1, 5'b10001, 1'b0, 1'b0);
    send(8'd50, 8'd60, 1'b1, 1'b1, 1'b1, 5'b10010, 1'b1, 1'b0);
    drain();
    chk("t1_last_data", 32'(wr_data), 32'h0F0CB);
    chk("t1_ready_wait", 32'(pt_ready), 32'd0);
    chk("t1_rd_bank", 32'(rd_bank), 32'd0);

    // 2: edge swaps, display reads back the frame from bank 1
    edge_swap(1'b1);
    chk("t2_rb_x0", 32'(ram[5'b10000][9:2]), 32'd10);
    chk("t2_rb_x1", 32'(ram[5'b10001][9:2]), 32'd30);
    chk("t2_rb_x2", 32'(ram[5'b10010][9:2]), 32'd50);
    chk("t2_ready_fill", 32'(pt_ready), 32'd1);

    // 3: frame_drawn held high throughout; no edge means no swap
    send(8'd1, 8'd2, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0);
    send(8'd3, 8'd4, 1'b0, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0);
    snap = sw_cnt;
    repeat (10) @(negedge clk);
    chk("t3_no_swap_cnt", 32'(sw_cnt), 32'(snap));
    chk("t3_rd_bank_hold", 32'(rd_bank), 32'd1);
    chk("t3_ready_wait", 32'(pt_ready), 32'd0);
    drain();
    edge_swap(1'b0);

    // 4: DEPTH+5 beats into bank 1, truncated at DEPTH words
    chk("t4_ovf_before", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH + 5; i++) begin
      send(8'(i), 8'(i + 100), 1'(i), (i == DEPTH + 4), (i < DEPTH),
           {1'b1, 4'(i)}, (i == DEPTH - 1), 1'b0);
    end
    drain();
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_eof_word", 32'(ram[5'b11111][1]), 32'd1);
    chk("t4_ready_wait", 32'(pt_ready), 32'd0);
    edge_swap(1'b1);

    // 5: last beat accepted on the same cycle as a frame_drawn rise
    @(negedge clk); frame_drawn = 1'b0;
    send(8'd5, 8'd6, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0);
    send(8'd7, 8'd8, 1'b1, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b1);
    snap = sw_cnt;
    repeat (5) @(negedge clk);
    chk("t5_no_swap_cnt", 32'(sw_cnt), 32'(snap));
    chk("t5_rd_bank_hold", 32'(rd_bank), 32'd1);
    chk("t5_ready_wait", 32'(pt_ready), 32'd0);
    drain();
    edge_swap(1'b0);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);

    // 6: reset mid-frame, then a one-point frame from {1,0}
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 20), 8'(i + 30), 1'b1, 1'b0, 1'b1, {1'b1, 4'(i)}, 1'b0, 1'b0);
    end
    drain();
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    chk("t6_wr_addr", 32'(wr_addr), 32'd0);
    chk("t6_wr_data", 32'(wr_data), 32'd0);
    chk("t6_rd_bank", 32'(rd_bank), 32'd0);
    chk("t6_swap", 32'(swap_pulse), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_ready", 32'(pt_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    send(8'd77, 8'd88, 1'b1, 1'b1, 1'b1, 5'b10000, 1'b1, 1'b0);
    drain();
    chk("t6_ready_wait", 32'(pt_ready), 32'd0);
    chk("t6_rd_bank_end", 32'(rd_bank), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
